// File: rtl/fpu_int_to_float.sv
// rtl/fpu_int_to_float.sv - three-stage int32/uint32 to binary32 converter (FCVT.S.W / FCVT.S.WU)
// Define FPU_RM_EN to honour RM in the round stage; otherwise round-to-nearest-even is fixed.
module fpu_int_to_float (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] DATA1,
    input  logic        UNSIGNED,
    input  logic [2:0]  RM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic        INEXACT
);

    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [31:0] s1_mag_q;
    logic        s1_sign_d;
    logic [31:0] s1_mag_d;

    logic        s2_valid_q;
    logic        s2_sign_q;
    logic        s2_zero_q;
    logic [7:0]  s2_exp_q;
    logic [31:0] s2_norm_q;
    logic [4:0]  s2_lz;
    logic        s2_zero_d;
    logic [7:0]  s2_exp_d;
    logic [31:0] s2_norm_d;

    logic        out_valid_q;
    logic [31:0] result_q;
    logic        inexact_q;
    logic [31:0] result_d;
    logic        inexact_d;

    logic        s1_advance;
    logic        s2_advance;
    logic        s3_ready;
    logic        s2_ready;

`ifdef FPU_RM_EN
    logic [2:0]  s1_rm_q;
    logic [2:0]  s2_rm_q;
`else
    logic        unused_rm;
    assign unused_rm = ^RM;
`endif

    // A stage may load when it is empty or its contents are leaving this cycle.
    assign s3_ready   = ~out_valid_q | OUT_READY;
    assign s2_advance = s2_valid_q & s3_ready;
    assign s2_ready   = ~s2_valid_q | s2_advance;
    assign s1_advance = s1_valid_q & s2_ready;
    assign IN_READY   = ~s1_valid_q | s1_advance;

    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign INEXACT   = inexact_q;

    function automatic logic [4:0] clz32(input logic [31:0] v);
        logic [4:0] n;
        n = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 5'(31 - i);
        end
        return n;
    endfunction

    always_comb begin
        s1_sign_d = ~UNSIGNED & DATA1[31];
        s1_mag_d  = s1_sign_d ? (~DATA1 + 32'd1) : DATA1;
    end

    always_comb begin
        s2_lz     = clz32(s1_mag_q);
        s2_norm_d = s1_mag_q << s2_lz;
        s2_exp_d  = 8'd158 - {3'b000, s2_lz};
        s2_zero_d = (s1_mag_q == 32'd0);
    end

    logic [22:0] mant;
    logic        guard_bit;
    logic        sticky_bit;
    logic        rne_inc;
    logic        incr;
    logic [23:0] mant_sum;
    logic [7:0]  exp_r;

    always_comb begin
        mant       = s2_norm_q[30:8];
        guard_bit  = s2_norm_q[7];
        sticky_bit = |s2_norm_q[6:0];
        rne_inc    = guard_bit & (sticky_bit | mant[0]);
        incr       = rne_inc;
`ifdef FPU_RM_EN
        case (s2_rm_q)
            3'b001:  incr = 1'b0;
            3'b010:  incr = s2_sign_q & (guard_bit | sticky_bit);
            3'b011:  incr = ~s2_sign_q & (guard_bit | sticky_bit);
            3'b100:  incr = guard_bit;
            default: incr = rne_inc;
        endcase
`endif
        // Carry out of the mantissa wraps it to zero and bumps the exponent.
        mant_sum = {1'b0, mant} + {23'd0, incr};
        exp_r    = s2_exp_q + {7'd0, mant_sum[23]};
        if (s2_zero_q) begin
            result_d  = 32'd0;
            inexact_d = 1'b0;
        end else begin
            result_d  = {s2_sign_q, exp_r, mant_sum[22:0]};
            inexact_d = guard_bit | sticky_bit;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= 32'd0;
`ifdef FPU_RM_EN
            s1_rm_q    <= 3'd0;
`endif
        end else if (IN_READY) begin
            s1_valid_q <= IN_VALID;
            if (IN_VALID) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
`ifdef FPU_RM_EN
                s1_rm_q   <= RM;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= 8'd0;
            s2_norm_q  <= 32'd0;
`ifdef FPU_RM_EN
            s2_rm_q    <= 3'd0;
`endif
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_advance) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s2_zero_d;
                s2_exp_q  <= s2_exp_d;
                s2_norm_q <= s2_norm_d;
`ifdef FPU_RM_EN
                s2_rm_q   <= s1_rm_q;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            inexact_q   <= 1'b0;
        end else if (s3_ready) begin
            out_valid_q <= s2_valid_q;
            if (s2_advance) begin
                result_q  <= result_d;
                inexact_q <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_fpu_int_to_float.sv
// tb/tb_fpu_int_to_float.sv - scoreboard bench for fpu_int_to_float against an arithmetic reference model
module tb_fpu_int_to_float;

    logic        CLK;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] DATA1;
    logic        UNSIGNED;
    logic [2:0]  RM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        INEXACT;

    fpu_int_to_float dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .DATA1    (DATA1),
        .UNSIGNED (UNSIGNED),
        .RM       (RM),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .RESULT   (RESULT),
        .INEXACT  (INEXACT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [32:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int rdy_mode = 0;
    int unsigned start_cyc = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Reference: exact integer value, then rounding decided on the discarded remainder.
    function automatic logic [32:0] model(input logic [31:0] d, input logic u, input logic [2:0] rm_in);
        longint m, q, r, half;
        logic   sgn, nx, inc;
        int     e, sh;
        logic [2:0] mode;
        logic [7:0] ef;
        logic [22:0] fr;
`ifdef FPU_RM_EN
        mode = rm_in;
`else
        mode = 3'b000 & rm_in;
`endif
        m   = u ? longint'({32'd0, d}) : longint'($signed(d));
        sgn = (m < 0);
        if (sgn) m = -m;
        if (m == 0) return 33'd0;
        e = 0;
        while ((longint'(1) << (e + 1)) <= m) e++;
        nx  = 1'b0;
        inc = 1'b0;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh   = e - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = longint'(1) << (sh - 1);
            nx   = (r != 0);
            case (mode)
                3'b001:  inc = 1'b0;
                3'b010:  inc = sgn && nx;
                3'b011:  inc = !sgn && nx;
                3'b100:  inc = (r >= half);
                default: inc = (r > half) || (r == half && q[0]);
            endcase
        end
        q = q + longint'(inc);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        ef = 8'(e + 127);
        fr = q[22:0];
        return {nx, sgn, ef, fr};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'b0;
            default: OUT_READY = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic send(input logic [31:0] d, input logic u, input logic [2:0] rm_in, input logic [32:0] want);
        bit acc;
        acc       = 1'b0;
        IN_VALID  = 1'b1;
        DATA1     = d;
        UNSIGNED  = u;
        RM        = rm_in;
        start_cyc = cyc;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge CLK);
            if (IN_READY) begin
                exp_q.push_back(want);
                n_pushed++;
                acc = 1'b1;
            end
            tick();
        end
        IN_VALID = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout: data %h never accepted", d);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || OUT_VALID) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            checks++;
            $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
        end
    endtask

    task automatic send_lat(input logic [31:0] d, input logic u, input logic [32:0] want);
        int lat;
        send(d, u, 3'b000, want);
        for (int t = 0; t < 10 && !OUT_VALID; t++) tick();
        lat = int'(cyc - start_cyc);
        chk("latency", 33'(lat), 33'd3);
        drain();
    endtask

    // Monitor: every delivered result is matched against the head of the scoreboard.
    always @(negedge CLK) begin
        if (RESET_N && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %h with nothing outstanding", {INEXACT, RESULT});
            end else begin
                chk("result", {INEXACT, RESULT}, exp_q.pop_front());
                n_popped++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] rand_data();
        logic [31:0] v;
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(0, 300)) : 32'($urandom_range(0, 300));
            2:       v = 32'h1 << $urandom_range(0, 31);
            3:       v = {$urandom_range(1, 32'hFFFFFF), 8'h80} >> $urandom_range(0, 6);
            default: v = edges[$urandom_range(0, 4)];
        endcase
        return v;
    endfunction

    logic [31:0] bp_data [6];
    logic [32:0] held;
    bit          have_held;
    int          n_acc;
    int          stale;

    initial begin
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        DATA1     = 32'd0;
        UNSIGNED  = 1'b0;
        RM        = 3'd0;
        OUT_READY = 1'b1;
        #12;
        chk("reset_out_valid", 33'(OUT_VALID), 33'd0);
        chk("reset_result", {INEXACT, RESULT}, 33'd0);
        chk("reset_in_ready", 33'(IN_READY), 33'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();

        send_lat(32'h00000001, 1'b0, 33'h0_3F800000);
        send_lat(32'hFFFFFFFF, 1'b0, 33'h0_BF800000);
        send_lat(32'h00000000, 1'b0, 33'h0_00000000);
        send_lat(32'h80000000, 1'b0, 33'h0_CF000000);

        send(32'h01000001, 1'b0, 3'b000, 33'h1_4B800000);
        send(32'h01000003, 1'b0, 3'b000, 33'h1_4B800002);
        send(32'h7FFFFFFF, 1'b0, 3'b000, 33'h1_4F000000);
        send(32'hFFFFFFFF, 1'b1, 3'b000, 33'h1_4F800000);
        send(32'h80000000, 1'b1, 3'b000, 33'h0_4F000000);
`ifdef FPU_RM_EN
        send(32'h7FFFFFFF, 1'b0, 3'b001, 33'h1_4EFFFFFF);
        send(32'h80000001, 1'b0, 3'b010, 33'h1_CF000000);
        send(32'h80000001, 1'b0, 3'b011, 33'h1_CEFFFFFF);
`else
        send(32'h7FFFFFFF, 1'b0, 3'b001, 33'h1_4F000000);
        send(32'h80000001, 1'b0, 3'b010, 33'h1_CF000000);
        send(32'h80000001, 1'b0, 3'b011, 33'h1_CF000000);
`endif
        drain();

        // Backpressure: six back-to-back requests against a five-cycle stall.
        for (int i = 0; i < 6; i++) bp_data[i] = $urandom | 32'h00100000;
        rdy_mode  = 1;
        OUT_READY = 1'b0;
        n_acc     = 0;
        have_held = 1'b0;
        held      = 33'd0;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1;
            DATA1    = bp_data[n_acc];
            UNSIGNED = 1'b0;
            RM       = 3'b000;
            @(negedge CLK);
            if (OUT_VALID && !have_held) begin
                held      = {INEXACT, RESULT};
                have_held = 1'b1;
            end
            if (IN_READY) begin
                exp_q.push_back(model(bp_data[n_acc], 1'b0, 3'b000));
                n_pushed++;
                n_acc++;
            end
            tick();
        end
        chk("bp_accepts", 33'(n_acc), 33'd3);
        chk("bp_in_ready_low", 33'(IN_READY), 33'd0);
        chk("bp_result_hold", {INEXACT, RESULT}, held);
        chk("bp_first_result", held, model(bp_data[0], 1'b0, 3'b000));
        rdy_mode = 0;
        tick();
        for (int i = n_acc; i < 6; i++) send(bp_data[i], 1'b0, 3'b000, model(bp_data[i], 1'b0, 3'b000));
        drain();

        // Reset with three requests in flight.
        rdy_mode  = 1;
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h00000100 + 32'(i), 1'b0, 3'b000, model(32'h00000100 + 32'(i), 1'b0, 3'b000));
        chk("rst_pre_valid", 33'(OUT_VALID), 33'd1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("rst_async_valid", 33'(OUT_VALID), 33'd0);
        chk("rst_async_result", {INEXACT, RESULT}, 33'd0);
        chk("rst_in_ready", 33'(IN_READY), 33'd1);
        n_pushed -= exp_q.size();
        exp_q.delete();
        rdy_mode = 0;
        tick();
        tick();
        @(negedge CLK);
        RESET_N = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge CLK);
            if (OUT_VALID) stale++;
        end
        chk("rst_no_stale", 33'(stale), 33'd0);

        // Randomised traffic with random stalls and rounding modes.
        rdy_mode = 2;
        tick();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] d;
            logic        u;
            logic [2:0]  r;
            d = rand_data();
            u = ($urandom_range(0, 1) != 0);
            r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) tick();
            send(d, u, r, model(d, u, r));
        end
        rdy_mode = 0;
        tick();
        drain();
        chk("all_delivered", 33'(n_popped), 33'(n_pushed));
        chk("queue_empty", 33'(exp_q.size()), 33'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
